pc_seq: RTL and testbench

Parametrised program-counter sequencer; the successor to the fixed 4-bit PC.
- Generalises address width.
- Adds a configurable branch-offset width, absolute jump, call/return through an internal return-address stack (RAS), and stall.
- Sits between the instruction decoder/ALU and instruction memory. Drives the fetch address every cycle.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_seq_if.sv | 30 +++
 rtl/ras_lifo.sv | 56 +++++
 rtl/pc_seq.sv | 110 +++++++++++
 tb/tb_pc_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

  // Source of the next PC, in decreasing priority order.
  typedef enum logic [2:0] {
    SrcRst,
    SrcHold,
    SrcRet,
    SrcCall,
    SrcJmp,
    SrcBr,
    SrcInc
  } pc_src_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Request/status bundle between decoder/ALU (master) and the PC sequencer (slave).
interface pc_seq_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned OW = 4
);
  logic          set_pc;
  logic          stall;
  logic          br_en;
  logic          alu_eq;
  logic [OW-1:0] br_off;
  logic          jmp_en;
  logic          call_en;
  logic          ret_en;
  logic [AW-1:0] jmp_addr;
  logic [AW-1:0] pc_curr;
  logic          ras_empty;
  logic          ras_full;
  logic          ovf;
  logic          unf;

  modport master (
    output set_pc, stall, br_en, alu_eq, br_off, jmp_en, call_en, ret_en, jmp_addr,
    input  pc_curr, ras_empty, ras_full, ovf, unf
  );

  modport slave (
    input  set_pc, stall, br_en, alu_eq, br_off, jmp_en, call_en, ret_en, jmp_addr,
    output pc_curr, ras_empty, ras_full, ovf, unf
  );
endinterface

// File: rtl/ras_lifo.sv
// Return-address stack: LIFO of AW-bit entries with a count register.
// Only the count is reset; entry storage keeps stale contents.
module ras_lifo
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW        = 4,
  parameter int unsigned RAS_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int unsigned CW = cnt_width(RAS_DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] mem_q [RAS_DEPTH];

  assign full  = (count_q == CW'(RAS_DEPTH));
  assign empty = (count_q == '0);

  // Top-of-stack read; value is meaningless while empty.
  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(RAS_DEPTH); i++) begin
      if (CW'(i) == count_q - CW'(1)) dout = mem_q[i];
    end
  end

  // Next count: clear beats push/pop; guarded against over/underflow.
  always_comb begin
    count_d = count_q;
    if (clr)                count_d = '0;
    else if (push && !full) count_d = count_q + CW'(1);
    else if (pop && !empty) count_d = count_q - CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Entry storage, written at the current count slot on a legal push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RAS_DEPTH); i++) begin
      if (!clr && push && !full && CW'(i) == count_q) mem_q[i] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: prioritised next-PC mux, PC register and
// return-address stack, with registered overflow/underflow pulses.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned   AW        = 4,
  parameter int unsigned   OW        = 4,
  parameter int unsigned   RAS_DEPTH = 2,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input logic     clk,
  input logic     rst_n,
  pc_seq_if.slave bus
);
  logic [AW-1:0] pc_q, pc_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] ras_top;
  logic          ras_full, ras_empty;
  logic          ras_push, ras_pop, ras_clr;
  pc_src_e       src;

  assign pc_inc  = pc_q + AW'(1);
  // Size cast of a signed value sign-extends the offset to AW bits.
  assign off_ext = AW'($signed(bus.br_off));

  // Pick the winning request; lower-priority requests are ignored entirely.
  always_comb begin
    src = SrcInc;
    if (bus.set_pc)                  src = SrcRst;
    else if (bus.stall)              src = SrcHold;
    else if (bus.ret_en)             src = SrcRet;
    else if (bus.call_en)            src = SrcCall;
    else if (bus.jmp_en)             src = SrcJmp;
    else if (bus.br_en && bus.alu_eq) src = SrcBr;
  end

  // Next PC and RAS controls for the selected source.
  always_comb begin
    pc_d     = pc_inc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_clr  = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    case (src)
      SrcRst: begin
        pc_d    = RESET_VEC;
        ras_clr = 1'b1;
      end
      SrcHold: pc_d = pc_q;
      SrcRet: begin
        if (!ras_empty) begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      SrcCall: begin
        if (!ras_full) begin
          pc_d     = bus.jmp_addr;
          ras_push = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      SrcJmp:  pc_d = bus.jmp_addr;
      SrcBr:   pc_d = pc_q + off_ext;
      default: pc_d = pc_inc;
    endcase
  end

  // PC and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_lifo #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ras_clr),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_inc),
    .dout  (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  assign bus.pc_curr   = pc_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq (AW=4, OW=4, RAS_DEPTH=2, RESET_VEC=0).
module tb_pc_seq;
  typedef struct packed {
    logic [3:0] pc;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   step_no;

  pc_seq_if #(.AW(4), .OW(4)) bus ();

  pc_seq #(
    .AW        (4),
    .OW        (4),
    .RAS_DEPTH (2),
    .RESET_VEC (4'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] pc, input logic e, input logic f,
                              input logic o, input logic u);
    exp_t r;
    r.pc = pc; r.empty = e; r.full = f; r.ovf = o; r.unf = u;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input exp_t e);
    exp_t a;
    a.pc = bus.pc_curr; a.empty = bus.ras_empty; a.full = bus.ras_full;
    a.ovf = bus.ovf; a.unf = bus.unf;
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s #%0d: got pc=%0d empty=%b full=%b ovf=%b unf=%b, want pc=%0d empty=%b full=%b ovf=%b unf=%b",
                  name, idx, a.pc, a.empty, a.full, a.ovf, a.unf,
                  e.pc, e.empty, e.full, e.ovf, e.unf);
  endtask

  // Drive one cycle of requests now (at a negedge), queue the post-edge expectation.
  task automatic step(input logic sp, input logic st, input logic br, input logic eq,
                      input logic [3:0] off, input logic jmp, input logic call,
                      input logic ret, input logic [3:0] addr, input exp_t e);
    bus.set_pc = sp; bus.stall = st; bus.br_en = br; bus.alu_eq = eq; bus.br_off = off;
    bus.jmp_en = jmp; bus.call_en = call; bus.ret_en = ret; bus.jmp_addr = addr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.set_pc = 0; bus.stall = 0; bus.br_en = 0; bus.alu_eq = 0; bus.br_off = '0;
    bus.jmp_en = 0; bus.call_en = 0; bus.ret_en = 0; bus.jmp_addr = '0;
  endtask

  // Monitor: compare DUT state just after each rising edge against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        check("seq", step_no, e);
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0; step_no = 0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset", 0, mk(4'd0, 1, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential count with wrap.
    for (int i = 0; i < 16; i++) step(0,0,0,0,4'd0,0,0,0,4'd0, mk(4'((i + 1) % 16), 1, 0, 0, 0));

    // Relative branches from pc=0: +7, -8, 0, not-taken.
    step(0,0,1,1,4'd7,0,0,0,4'd0, mk(4'd7,  1, 0, 0, 0));
    step(0,0,1,1,4'h8,0,0,0,4'd0, mk(4'd15, 1, 0, 0, 0));
    step(0,0,1,1,4'd0,0,0,0,4'd0, mk(4'd15, 1, 0, 0, 0));
    step(0,0,1,0,4'd5,0,0,0,4'd0, mk(4'd0,  1, 0, 0, 0));

    // Call/return nesting.
    step(0,0,0,0,4'd0,1,0,0,4'd3,  mk(4'd3,  1, 0, 0, 0));
    step(0,0,0,0,4'd0,0,1,0,4'd10, mk(4'd10, 0, 0, 0, 0));
    step(0,0,0,0,4'd0,0,1,0,4'd12, mk(4'd12, 0, 1, 0, 0));
    step(0,0,0,0,4'd0,0,0,1,4'd0,  mk(4'd11, 0, 0, 0, 0));
    step(0,0,0,0,4'd0,0,0,1,4'd0,  mk(4'd4,  1, 0, 0, 0));

    // Fill RAS (returns 5 then 8), move to pc=5, overflow.
    step(0,0,0,0,4'd0,0,1,0,4'd7,  mk(4'd7,  0, 0, 0, 0));
    step(0,0,0,0,4'd0,0,1,0,4'd4,  mk(4'd4,  0, 1, 0, 0));
    step(0,0,0,0,4'd0,1,0,0,4'd5,  mk(4'd5,  0, 1, 0, 0));
    step(0,0,0,0,4'd0,0,1,0,4'd9,  mk(4'd6,  0, 1, 1, 0));
    step(0,0,0,0,4'd0,0,0,0,4'd0,  mk(4'd7,  0, 1, 0, 0));
    step(0,0,0,0,4'd0,0,0,1,4'd0,  mk(4'd8,  0, 0, 0, 0));
    step(0,0,0,0,4'd0,0,0,1,4'd0,  mk(4'd5,  1, 0, 0, 0));
    // Underflow from pc=2.
    step(0,0,0,0,4'd0,1,0,0,4'd2,  mk(4'd2,  1, 0, 0, 0));
    step(0,0,0,0,4'd0,0,0,1,4'd0,  mk(4'd3,  1, 0, 0, 1));
    step(0,0,0,0,4'd0,0,0,0,4'd0,  mk(4'd4,  1, 0, 0, 0));

    // Stall holds despite a taken branch.
    for (int i = 0; i < 3; i++) step(0,1,1,1,4'd3,0,0,0,4'd0, mk(4'd4, 1, 0, 0, 0));
    // set_pc overrides stall and call, empties RAS.
    step(0,0,0,0,4'd0,0,1,0,4'd1,  mk(4'd1,  0, 0, 0, 0));
    step(1,1,0,0,4'd0,0,1,0,4'd9,  mk(4'd0,  1, 0, 0, 0));
    // ret+call+jmp with non-empty RAS: pop only (top = 7).
    step(0,0,0,0,4'd0,0,1,0,4'd6,  mk(4'd6,  0, 0, 0, 0));
    step(0,0,0,0,4'd0,0,1,0,4'd10, mk(4'd10, 0, 1, 0, 0));
    step(0,0,0,0,4'd0,1,1,1,4'd3,  mk(4'd7,  0, 0, 0, 0));
    // jmp beats branch; then negative branch 12-3=9.
    step(0,0,1,1,4'd3,1,0,0,4'd12, mk(4'd12, 0, 0, 0, 0));
    step(0,0,1,1,4'hD,0,0,0,4'd0,  mk(4'd9,  0, 0, 0, 0));
    step(0,0,0,0,4'd0,0,1,0,4'd2,  mk(4'd2,  0, 1, 0, 0));

    // Async reset between edges.
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, mk(4'd0, 1, 0, 0, 0));
    @(negedge clk);
    check("rst_hold", 0, mk(4'd0, 1, 0, 0, 0));
    rst_n = 1'b1;
    step(0,0,0,0,4'd0,0,0,1,4'd0,  mk(4'd1,  1, 0, 0, 1));
    step(0,0,0,0,4'd0,0,0,0,4'd0,  mk(4'd2,  1, 0, 0, 0));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
